// File: rtl/mmc1a_mapper.sv
// MMC1A bank-switching mapper: 5-bit serial register port plus PRG/CHR/mirroring decode.
// Optional `MMC1A_SRAM_GATE_EN: PRG bit 4 gates the SRAM enable (MMC1B-style).
module mmc1a_mapper (
  input  logic M2,
  input  logic nRES,
  input  logic nROMSEL,
  input  logic CPU_RnW,
  input  logic CPU_D0,
  input  logic CPU_D7,
  input  logic CPU_A13,
  input  logic CPU_A14,
  input  logic PPU_A10,
  input  logic PPU_A11,
  input  logic PPU_A12,
  output logic PRG_A14,
  output logic PRG_A15,
  output logic PRG_A16,
  output logic PRG_A17,
  output logic CHR_A12,
  output logic CHR_A13,
  output logic CHR_A14,
  output logic CHR_A15,
  output logic CHR_A16,
  output logic PRG_nCE,
  output logic SRAM_CE,
  output logic CIRAM_A10
);

  // Only four bits of history are needed: the fifth bit comes straight from CPU_D0.
  logic [3:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       w_prev_q, w_prev_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  logic       w_now;
  logic       accept;
  logic [4:0] load_val;

  assign w_now    = ~nROMSEL & ~CPU_RnW;
  assign accept   = w_now & ~w_prev_q;
  assign load_val = {CPU_D0, sr_q};

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    w_prev_d = w_now;
    ctrl_d   = ctrl_q;
    chr0_d   = chr0_q;
    chr1_d   = chr1_q;
    prg_d    = prg_q;
    if (accept) begin
      if (CPU_D7) begin
        sr_d        = 4'b0000;
        cnt_d       = 3'd0;
        ctrl_d[3:2] = 2'b11;
      end else if (cnt_q == 3'd4) begin
        sr_d  = 4'b0000;
        cnt_d = 3'd0;
        unique case ({CPU_A14, CPU_A13})
          2'b00:   ctrl_d = load_val;
          2'b01:   chr0_d = load_val;
          2'b10:   chr1_d = load_val;
          default: prg_d  = load_val;
        endcase
      end else begin
        sr_d  = {CPU_D0, sr_q[3:1]};
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge M2 or negedge nRES) begin
    if (!nRES) begin
      sr_q     <= 4'b0000;
      cnt_q    <= 3'd0;
      w_prev_q <= 1'b0;
      ctrl_q   <= 5'b01100;
      chr0_q   <= 5'b00000;
      chr1_q   <= 5'b00000;
      prg_q    <= 5'b00000;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      w_prev_q <= w_prev_d;
      ctrl_q   <= ctrl_d;
      chr0_q   <= chr0_d;
      chr1_q   <= chr1_d;
      prg_q    <= prg_d;
    end
  end

  always_comb begin
    unique case (ctrl_q[1:0])
      2'd0:    CIRAM_A10 = 1'b0;
      2'd1:    CIRAM_A10 = 1'b1;
      2'd2:    CIRAM_A10 = PPU_A10;
      default: CIRAM_A10 = PPU_A11;
    endcase
  end

  always_comb begin
    if (ctrl_q[4]) begin
      {CHR_A16, CHR_A15, CHR_A14, CHR_A13, CHR_A12} = PPU_A12 ? chr1_q : chr0_q;
    end else begin
      {CHR_A16, CHR_A15, CHR_A14, CHR_A13} = chr0_q[4:1];
      CHR_A12 = PPU_A12;
    end
  end

  // PRG_A17 bypasses the fixed-bank logic: it selects the 256 KB half in every mode.
  always_comb begin
    PRG_A17 = prg_q[3];
    unique case (ctrl_q[3:2])
      2'b10:   {PRG_A16, PRG_A15, PRG_A14} = CPU_A14 ? prg_q[2:0] : 3'b000;
      2'b11:   {PRG_A16, PRG_A15, PRG_A14} = CPU_A14 ? 3'b111 : prg_q[2:0];
      default: {PRG_A16, PRG_A15, PRG_A14} = {prg_q[2:1], CPU_A14};
    endcase
  end

  assign PRG_nCE = nROMSEL;

`ifdef MMC1A_SRAM_GATE_EN
  assign SRAM_CE = nROMSEL & CPU_A14 & CPU_A13 & ~prg_q[4];
`else
  logic unused_prg4;
  assign unused_prg4 = prg_q[4];
  assign SRAM_CE     = nROMSEL & CPU_A14 & CPU_A13;
`endif

endmodule

// File: tb/tb_mmc1a_mapper.sv
// Scoreboard bench for mmc1a_mapper: expected output vectors are queued as stimulus is
// driven and popped when the combinational outputs are sampled.
module tb_mmc1a_mapper;

  logic M2 = 1'b0;
  logic nRES, nROMSEL, CPU_RnW, CPU_D0, CPU_D7, CPU_A13, CPU_A14;
  logic PPU_A10, PPU_A11, PPU_A12;
  logic PRG_A14, PRG_A15, PRG_A16, PRG_A17;
  logic CHR_A12, CHR_A13, CHR_A14, CHR_A15, CHR_A16;
  logic PRG_nCE, SRAM_CE, CIRAM_A10;

  always #5 M2 = ~M2;

  mmc1a_mapper dut (
    .M2(M2), .nRES(nRES), .nROMSEL(nROMSEL), .CPU_RnW(CPU_RnW),
    .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
    .PPU_A10(PPU_A10), .PPU_A11(PPU_A11), .PPU_A12(PPU_A12),
    .PRG_A14(PRG_A14), .PRG_A15(PRG_A15), .PRG_A16(PRG_A16), .PRG_A17(PRG_A17),
    .CHR_A12(CHR_A12), .CHR_A13(CHR_A13), .CHR_A14(CHR_A14), .CHR_A15(CHR_A15),
    .CHR_A16(CHR_A16), .PRG_nCE(PRG_nCE), .SRAM_CE(SRAM_CE), .CIRAM_A10(CIRAM_A10)
  );

  // {PRG_A17..A14, CHR_A16..A12, PRG_nCE, SRAM_CE, CIRAM_A10}
  logic [11:0] obs_vec;
  assign obs_vec = {PRG_A17, PRG_A16, PRG_A15, PRG_A14,
                    CHR_A16, CHR_A15, CHR_A14, CHR_A13, CHR_A12,
                    PRG_nCE, SRAM_CE, CIRAM_A10};

  localparam logic [11:0] M_PRG = 12'hF00, M_CHR = 12'h0F8, M_NCE = 12'h004,
                          M_SRAM = 12'h002, M_CIR = 12'h001, M_ALL = 12'hFFF;

  typedef struct {
    string       tag;
    logic [11:0] exp;
    logic [11:0] mask;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register file plus bit-collection accumulator.
  logic [4:0] m_ctrl, m_chr0, m_chr1, m_prg, m_acc;
  int         m_n;

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_ctrl = 5'b01100; m_chr0 = '0; m_chr1 = '0; m_prg = '0; m_acc = '0; m_n = 0;
  endfunction

  function automatic void m_write(input logic d0, input logic d7, input logic a14, input logic a13);
    if (d7) begin
      m_acc = '0; m_n = 0;
      m_ctrl[3:2] = 2'b11;
    end else begin
      m_acc[m_n] = d0;
      m_n++;
      if (m_n == 5) begin
        if (!a14 && !a13) m_ctrl = m_acc;
        if (!a14 &&  a13) m_chr0 = m_acc;
        if ( a14 && !a13) m_chr1 = m_acc;
        if ( a14 &&  a13) m_prg  = m_acc;
        m_acc = '0; m_n = 0;
      end
    end
  endfunction

  function automatic logic [11:0] m_out();
    logic [3:0] p;
    logic [4:0] c;
    logic       cir, sram;
    p[3] = m_prg[3];
    if (m_ctrl[3] == 1'b0)      p[2:0] = {m_prg[2:1], CPU_A14};
    else if (m_ctrl[2] == 1'b0) p[2:0] = CPU_A14 ? m_prg[2:0] : 3'd0;
    else                        p[2:0] = CPU_A14 ? 3'd7 : m_prg[2:0];
    if (m_ctrl[4]) c = PPU_A12 ? m_chr1 : m_chr0;
    else           c = {m_chr0[4:1], PPU_A12};
    case (m_ctrl[1:0])
      2'd0: cir = 1'b0;
      2'd1: cir = 1'b1;
      2'd2: cir = PPU_A10;
      default: cir = PPU_A11;
    endcase
    sram = nROMSEL & CPU_A14 & CPU_A13;
`ifdef MMC1A_SRAM_GATE_EN
    sram = sram & ~m_prg[4];
`endif
    return {p, c, nROMSEL, sram, cir};
  endfunction

  task automatic ser_write(input logic d0, input logic d7, input logic a14, input logic a13);
    @(negedge M2);
    nROMSEL = 1'b0; CPU_RnW = 1'b0; CPU_D0 = d0; CPU_D7 = d7; CPU_A14 = a14; CPU_A13 = a13;
    m_write(d0, d7, a14, a13);
    @(negedge M2);
    nROMSEL = 1'b1; CPU_RnW = 1'b1;
  endtask

  // Write strobe held for two cycles with different data; only the first may count.
  task automatic dbl_write(input logic d0, input logic a14, input logic a13);
    @(negedge M2);
    nROMSEL = 1'b0; CPU_RnW = 1'b0; CPU_D0 = d0; CPU_D7 = 1'b0; CPU_A14 = a14; CPU_A13 = a13;
    m_write(d0, 1'b0, a14, a13);
    @(negedge M2);
    CPU_D0 = ~d0;
    @(negedge M2);
    nROMSEL = 1'b1; CPU_RnW = 1'b1;
  endtask

  task automatic ser_load(input logic [4:0] v, input logic a14, input logic a13);
    for (int i = 0; i < 5; i++) ser_write(v[i], 1'b0, a14, a13);
  endtask

  task automatic pulse_reset();
    @(negedge M2);
    nRES = 1'b0;
    m_reset();
    #2 nRES = 1'b1;
  endtask

  // Drive a read-side input pattern; queue either a fixed expectation or the model's.
  task automatic probe(input string tag, input logic nrs, input logic a14, input logic a13,
                       input logic p10, input logic p11, input logic p12,
                       input bit use_model, input logic [11:0] exp, input logic [11:0] mask);
    exp_t e, got;
    @(negedge M2);
    nROMSEL = nrs; CPU_RnW = 1'b1; CPU_A14 = a14; CPU_A13 = a13;
    PPU_A10 = p10; PPU_A11 = p11; PPU_A12 = p12;
    e.tag  = tag;
    e.exp  = use_model ? m_out() : exp;
    e.mask = use_model ? M_ALL : mask;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty, got %03h expected entry", tag, obs_vec);
    end else begin
      got = sb_q.pop_front();
      check_val(got.tag, obs_vec & got.mask, got.exp & got.mask);
    end
  endtask

  task automatic probe_rand(input string tag);
    probe(tag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'b1, 12'h000, M_ALL);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRES = 1'b0; nROMSEL = 1'b1; CPU_RnW = 1'b1; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
    CPU_A13 = 1'b0; CPU_A14 = 1'b0; PPU_A10 = 1'b0; PPU_A11 = 1'b0; PPU_A12 = 1'b0;
    m_reset();
    repeat (2) @(negedge M2);
    nRES = 1'b1;

    probe("rst_state", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h708, M_PRG | M_CHR | M_NCE | M_CIR);
    probe("rst_a14lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, M_PRG | M_CHR);

    ser_load(5'b10011, 1'b0, 1'b0);
    probe("ctrl_horiz_1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h001, M_CIR);
    probe("ctrl_horiz_0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, M_CIR);

    ser_load(5'b00101, 1'b0, 1'b1);
    ser_load(5'b11010, 1'b1, 1'b0);
    probe("chr4k_lo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h028, M_CHR);
    probe("chr4k_hi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0D0, M_CHR);

    ser_write(1'b0, 1'b1, 1'b0, 1'b0);
    ser_load(5'b00101, 1'b1, 1'b1);
    probe("prg_m3_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h500, M_PRG);
    probe("prg_m3_hi", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h700, M_PRG);

    ser_load(5'b10000, 1'b0, 1'b0);
    probe("ctrl_m0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h500, M_PRG);
    for (int i = 0; i < 3; i++) ser_write(1'b1, 1'b0, 1'b1, 1'b1);
    ser_write(1'b0, 1'b1, 1'b1, 1'b1);
    ser_load(5'b00000, 1'b1, 1'b1);
    probe("d7_prg_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, M_PRG);
    probe("d7_prg_hi", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h700, M_PRG);
    probe("d7_model", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, M_ALL);

    ser_write(1'b1, 1'b0, 1'b1, 1'b1);
    dbl_write(1'b0, 1'b1, 1'b1);
    ser_write(1'b1, 1'b0, 1'b1, 1'b1);
    ser_write(1'b0, 1'b0, 1'b1, 1'b1);
    ser_write(1'b1, 1'b0, 1'b1, 1'b1);
    probe("b2b_prg_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h500, M_PRG);

`ifdef MMC1A_SRAM_GATE_EN
    probe("sram_win", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h004, M_SRAM | M_NCE);
`else
    probe("sram_win", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h006, M_SRAM | M_NCE);
`endif
    probe("sram_a13lo", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h004, M_SRAM | M_NCE);
    probe("nce_low", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, M_SRAM | M_NCE);
    ser_load(5'b00101, 1'b1, 1'b1);
    probe("sram_prg4lo", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h006, M_SRAM | M_NCE);

    ser_write(1'b1, 1'b0, 1'b0, 1'b0);
    ser_write(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    probe("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h708, M_PRG | M_CHR | M_NCE | M_CIR);
    ser_load(5'b11110, 1'b0, 1'b0);
    probe("rst_mid_ctrl", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, M_ALL);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: ser_write(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: dbl_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: ser_write(1'($urandom_range(0, 1)), 1'b0,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
      probe_rand("rand_a");
      probe_rand("rand_b");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmc1a_mapper.md
Name: mmc1a_mapper

Overview:
Nintendo MMC1 (revision A) bank-switching mapper core for a NES cartridge board. The CPU writes through a 5-bit serial port in $8000-$FFFF to load four internal registers. Those registers drive the high PRG/CHR address lines, nametable mirroring (CIRAM_A10) and the PRG ROM/SRAM chip enables. The block sits between the CPU/PPU cartridge bus and the PRG ROM, CHR memory and SRAM.

Parameters:
None.

Ports:
M2  in  1  CPU M2 clock; the only clock; sequential logic on rising edge
nRES  in  1  asynchronous active-low reset
nROMSEL  in  1  0 = CPU access to $8000-$FFFF
CPU_RnW  in  1  1 = read, 0 = write
CPU_D0  in  1  serial data bit
CPU_D7  in  1  serial-port reset bit
CPU_A13  in  1  CPU address bit 13
CPU_A14  in  1  CPU address bit 14
PPU_A10, PPU_A11, PPU_A12  in  1 each  PPU address bits
PRG_A14..PRG_A17  out  1 each  PRG ROM bank address
CHR_A12..CHR_A16  out  1 each  CHR bank address
PRG_nCE  out  1  PRG ROM enable, active low
SRAM_CE  out  1  SRAM enable, active high
CIRAM_A10  out  1  nametable select to console VRAM

Behaviour:
- Write qualifier W = (nROMSEL==0 && CPU_RnW==0), sampled on rising M2. A registered flag holds the previous cycle's W.
- A write is accepted only if W=1 and the previous cycle's W=0. Consecutive-cycle writes are ignored.
- Accepted write with CPU_D7=1:
  - Shift register and bit counter clear to 0.
  - CTRL[3:2] set to 2'b11; other CTRL bits unchanged.
- Accepted write with CPU_D7=0:
  - CPU_D0 shifts in LSB-first: sr <= {D0, sr[4:1]}; counter increments.
  - On the 5th write, the 5-bit value {D0, sr[4:1]} loads the register selected by {CPU_A14, CPU_A13}: 00 CTRL, 01 CHR0, 10 CHR1, 11 PRG.
  - The same edge clears the shift register and counter.
- Async reset (nRES=0), any time including mid-sequence:
  - sr=0, counter=0, prev-W flag=0.
  - CTRL=5'b01100, CHR0=0, CHR1=0, PRG=0.
- All outputs are combinational from registers and address inputs. There is no output latency beyond the register update edge.
- CIRAM_A10 by CTRL[1:0]: 0 gives 0; 1 gives 1; 2 gives PPU_A10 (vertical); 3 gives PPU_A11 (horizontal).
- CHR outputs, selected by CTRL[4]:
  - CTRL[4]=0 (8 KB mode): CHR_A16..A13 = CHR0[4:1]; CHR_A12 = PPU_A12.
  - CTRL[4]=1 (4 KB mode): CHR_A16..A12 = PPU_A12 ? CHR1[4:0] : CHR0[4:0].
- PRG outputs, selected by CTRL[3:2]:
  - 0x (32 KB): PRG_A16..A15 = PRG[2:1]; PRG_A14 = CPU_A14.
  - 10 (fixed first): PRG_A16..A14 = CPU_A14 ? PRG[2:0] : 3'b000.
  - 11 (fixed last): PRG_A16..A14 = CPU_A14 ? 3'b111 : PRG[2:0].
  - All modes: PRG_A17 = PRG[3]. This is the MMC1A 256 KB-half bypass and is never forced by the fixed-bank logic.
- PRG_nCE = nROMSEL (pure pass-through).
- SRAM_CE = nROMSEL & CPU_A14 & CPU_A13, i.e. the $6000-$7FFF window. PRG[4] has no effect unless the optional feature is enabled.
- Reads (CPU_RnW=1) never change state.

Optional Feature:
MMC1A_SRAM_GATE_EN
- Defined: SRAM_CE = nROMSEL & CPU_A14 & CPU_A13 & ~PRG[4], so PRG bit 4 = 1 disables SRAM (MMC1B-style).
- Undefined: PRG[4] is stored but ignored; SRAM always enabled in its window.

Test Plan:
- Reset: pulse nRES low; nROMSEL=0, CPU_A14=1 -> PRG_A17..A14 = 0111. PPU_A12=1 -> CHR_A12=1, CHR_A16..A13=0000. CIRAM_A10=0.
- Control load: 5 separated writes to A14:A13=00 with D0 = 1,1,0,0,1 (value 10011) -> CTRL=10011. Then PPU_A11=1, PPU_A10=0 -> CIRAM_A10=1; PPU_A11=0 -> 0. CHR is in 4 KB mode.
- CHR 4K: with CTRL=10011, load CHR0=00101 and CHR1=11010 -> PPU_A12=0 gives CHR_A16..A12=00101; PPU_A12=1 gives 11010.
- PRG mode 3: load PRG=00101 (CTRL mode 11) -> CPU_A14=0 gives PRG_A17..A14=0101; CPU_A14=1 gives 0111.
- D7 reset mid-sequence: 3 bit-writes, then a write with D7=1, then 5 writes of 00000 to PRG -> PRG=00000, CTRL[3:2]=11. The earlier 3 bits are discarded.
- Back-to-back: W held low for 2 consecutive cycles -> only one bit shifted. SRAM check: nROMSEL=1, A14=A13=1 -> SRAM_CE=1; A13=0 -> 0; PRG_nCE follows nROMSEL.
